bcd_code_converter: RTL and testbench

//   Converts one BCD digit {d,c,b,a} (d = MSB) into a selectable 4-bit weighted or unweighted code.

---
 rtl/bcd_code_converter_if.sv | 24 ++
 rtl/bcd_code_converter.sv | 51 +++++
 tb/tb_bcd_code_converter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bcd_code_converter_if.sv
// Signal bundle for the BCD code converter: one BCD digit plus mode in,
// converted 4-bit code and non-BCD flag out.
interface bcd_code_converter_if;
  logic       d;
  logic       c;
  logic       b;
  logic       a;
  logic [1:0] mode;
  logic       out4;
  logic       out3;
  logic       out2;
  logic       out1;
  logic       err;

  modport master (
    output d, c, b, a, mode,
    input  out4, out3, out2, out1, err
  );

  modport slave (
    input  d, c, b, a, mode,
    output out4, out3, out2, out1, err
  );
endinterface

// File: rtl/bcd_code_converter.sv
// Registered BCD digit converter: Excess-3, 2421, Gray or 5421 selected by mode,
// with a flag for non-BCD inputs. One clock of latency.
module bcd_code_converter #(
  parameter logic [3:0] INVALID_CODE = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_code_converter_if.slave   bus
);

  logic [3:0] n;
  logic [3:0] code_d;
  logic [3:0] code_q;
  logic       err_d;
  logic       err_q;

  assign n = {bus.d, bus.c, bus.b, bus.a};

  always_comb begin
    code_d = INVALID_CODE;
    err_d  = 1'b1;
    if (n <= 4'd9) begin
      err_d = 1'b0;
      unique case (bus.mode)
        2'b00: code_d = n + 4'd3;
        // 2421 and 5421 keep 0..4 unchanged; upper half is offset by 6 or 3
        2'b01: code_d = (n < 4'd5) ? n : n + 4'd6;
        2'b10: code_d = n ^ (n >> 1);
        2'b11: code_d = (n < 4'd5) ? n : n + 4'd3;
        default: code_d = INVALID_CODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= 4'b0000;
      err_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      err_q  <= err_d;
    end
  end

  assign bus.out4 = code_q[3];
  assign bus.out3 = code_q[2];
  assign bus.out2 = code_q[1];
  assign bus.out1 = code_q[0];
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_code_converter.sv
// Scoreboard bench for bcd_code_converter: driver pushes expected results,
// monitor pops one per rising edge and also checks values hold between edges.
module tb_bcd_code_converter;

  logic clk;
  logic rst;

  bcd_code_converter_if bus ();

  bcd_code_converter #(.INVALID_CODE(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       err;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference: code tables written directly from the code definitions
  function automatic exp_t model(input logic r, input int n, input int m, input string tag);
    exp_t e;
    int aiken[10] = '{0, 1, 2, 3, 4, 11, 12, 13, 14, 15};
    int c5421[10] = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 12};
    e.tag = tag;
    if (r) begin
      e.code = 4'd0; e.err = 1'b0;
    end else if (n > 9) begin
      e.code = 4'd0; e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      case (m)
        0:       e.code = 4'(n + 3);
        1:       e.code = 4'(aiken[n]);
        2:       e.code = 4'(n ^ (n / 2));
        default: e.code = 4'(c5421[n]);
      endcase
    end
    return e;
  endfunction

  task automatic apply(input logic r, input int n, input int m, input string tag);
    logic [3:0] nv;
    @(negedge clk);
    nv       = 4'(n);
    rst      = r;
    bus.d    = nv[3];
    bus.c    = nv[2];
    bus.b    = nv[1];
    bus.a    = nv[0];
    bus.mode = 2'(m);
    exp_q.push_back(model(r, n, m, tag));
  endtask

  task automatic check(input exp_t e, input string phase);
    logic [3:0] got;
    got = {bus.out4, bus.out3, bus.out2, bus.out1};
    vectors++;
    if (got !== e.code || bus.err !== e.err) begin
      miscompares++;
      $display("FAIL %s %s: got out=%b err=%b, expected out=%b err=%b",
               e.tag, phase, got, bus.err, e.code, e.err);
    end
  endtask

  // Monitor: compare just after each edge, then again after the driver has
  // changed inputs, proving the outputs only move on the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e, "edge");
        #7;
        check(e, "hold");
      end
    end
  end

  initial begin
    int n, m;
    rst = 1'b1;
    bus.d = 1'b0; bus.c = 1'b0; bus.b = 1'b0; bus.a = 1'b0; bus.mode = 2'b00;

    apply(1'b1, 9, 0, "reset0");
    apply(1'b1, 9, 0, "reset1");
    apply(1'b0, 9, 0, "release");

    for (int i = 0; i < 10; i++) apply(1'b0, i, 0, "xs3_sweep");

    for (int mm = 0; mm < 4; mm++)
      for (int i = 10; i < 16; i++) apply(1'b0, i, mm, "invalid");
    apply(1'b0, 4, 0, "err_clear");

    for (int mm = 1; mm < 4; mm++) apply(1'b0, 7, mm, "n7_mode");
    for (int mm = 1; mm < 4; mm++) apply(1'b0, 5, mm, "n5_mode");

    for (int mm = 0; mm < 4; mm++)
      for (int i = 0; i < 10; i++) apply(1'b0, i, mm, "full_table");

    for (int i = 0; i < 8; i++) apply(i == 4, i, 0, "midstream_rst");

    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 15));
      m = int'($urandom_range(0, 3));
      apply(($urandom_range(0, 15) == 0), n, m, "random");
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #10;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
